// File: rtl/sc_up_transition_counter1.sv
// Bounded up/down event counter with optional falling-edge detection on the event inputs.
// It offers modulo or saturating bounds, synchronous clear, parallel load, and registered overflow/underflow pulses.
module sc_up_transition_counter1 #(
  parameter int DATAWIDTH = 8,
  parameter int MAXVALUE  = 255,
  parameter bit SATURATE  = 1'b0,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic                 SC_upTRANSITIONCOUNTER1_CLOCK_50,
  input  logic                 SC_upTRANSITIONCOUNTER1_RESET_InHigh,
  input  logic                 SC_upTRANSITIONCOUNTER1_clear_InLow,
  input  logic                 SC_upTRANSITIONCOUNTER1_load_InLow,
  input  logic [DATAWIDTH-1:0] SC_upTRANSITIONCOUNTER1_data_InBUS,
  input  logic                 SC_upTRANSITIONCOUNTER1_upcount_InLow,
  input  logic                 SC_upTRANSITIONCOUNTER1_downcount_InLow,
  output logic [DATAWIDTH-1:0] SC_upTRANSITIONCOUNTER1_data_OutBUS,
  output logic                 SC_upTRANSITIONCOUNTER1_overflow_Out,
  output logic                 SC_upTRANSITIONCOUNTER1_underflow_Out,
  output logic                 SC_upTRANSITIONCOUNTER1_zero_Out
);

  localparam logic [DATAWIDTH-1:0] MAX_C = DATAWIDTH'(MAXVALUE);
  localparam logic [DATAWIDTH-1:0] ONE_C = DATAWIDTH'(1);

  logic                 clk;
  logic                 srst;
  logic [DATAWIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 up_event, down_event;
  logic [DATAWIDTH-1:0] load_value;

  assign clk  = SC_upTRANSITIONCOUNTER1_CLOCK_50;
  assign srst = SC_upTRANSITIONCOUNTER1_RESET_InHigh;

  generate
    if (EDGE_MODE) begin : g_edge
      logic prev_up_q, prev_down_q, hist_valid_q;

      // hist_valid_q blocks the first cycle after reset.
      // A level that is already low at release is therefore not counted as an edge.
      always_ff @(posedge clk) begin
        if (srst) begin
          prev_up_q    <= 1'b1;
          prev_down_q  <= 1'b1;
          hist_valid_q <= 1'b0;
        end else begin
          prev_up_q    <= SC_upTRANSITIONCOUNTER1_upcount_InLow;
          prev_down_q  <= SC_upTRANSITIONCOUNTER1_downcount_InLow;
          hist_valid_q <= 1'b1;
        end
      end

      assign up_event   = hist_valid_q & prev_up_q & ~SC_upTRANSITIONCOUNTER1_upcount_InLow;
      assign down_event = hist_valid_q & prev_down_q & ~SC_upTRANSITIONCOUNTER1_downcount_InLow;
    end else begin : g_level
      assign up_event   = ~SC_upTRANSITIONCOUNTER1_upcount_InLow;
      assign down_event = ~SC_upTRANSITIONCOUNTER1_downcount_InLow;
    end
  endgenerate

  assign load_value = (SC_upTRANSITIONCOUNTER1_data_InBUS > MAX_C) ? MAX_C
                                                                   : SC_upTRANSITIONCOUNTER1_data_InBUS;

  always_comb begin
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (!SC_upTRANSITIONCOUNTER1_clear_InLow) begin
      count_d = '0;
    end else if (!SC_upTRANSITIONCOUNTER1_load_InLow) begin
      count_d = load_value;
    end else if (up_event && !down_event) begin
      if (count_q == MAX_C) begin
        overflow_d = 1'b1;
        count_d    = SATURATE ? MAX_C : '0;
      end else begin
        count_d = count_q + ONE_C;
      end
    end else if (down_event && !up_event) begin
      if (count_q == '0) begin
        underflow_d = 1'b1;
        count_d     = SATURATE ? '0 : MAX_C;
      end else begin
        count_d = count_q - ONE_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign SC_upTRANSITIONCOUNTER1_data_OutBUS   = count_q;
  assign SC_upTRANSITIONCOUNTER1_overflow_Out  = overflow_q;
  assign SC_upTRANSITIONCOUNTER1_underflow_Out = underflow_q;
  assign SC_upTRANSITIONCOUNTER1_zero_Out      = (count_q == '0);

endmodule
